seq_shift_add_multiplier: RTL

Parametrised sequential shift-add multiplier. It owns the operand registers, accumulator, step counter and control FSM, and offers a start/ready/done handshake to the surrounding datapath. It computes an N×N→2N product in N cycles, doing one combined add-and-shift step per cycle. A compile-time option adds signed (radix-2 Booth) operation.

---
 rtl/seq_shift_add_multiplier.sv | 78 +++++++
 1 files changed

// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier: N-cycle shift-add multiplier with start/ready/done handshake.
// Define SEQ_MULT_SIGNED_EN to add the signed_op port and radix-2 Booth signed mode.
module seq_shift_add_multiplier #(
  parameter int N = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic           signed_op,
`endif
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);
  localparam int CW = $clog2(N + 1);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [N-1:0] a, q, m;
  logic [CW-1:0] cnt;
  logic [N:0] s;
  logic go;
  assign ready = state == IDLE;
  assign busy = state == RUN;
  assign done = state == DONE;
  // The edge that leaves DONE may already accept the next op, giving N+1-cycle throughput.
  assign go = start && (state == IDLE || state == DONE);
`ifdef SEQ_MULT_SIGNED_EN
  logic q_1, sg;
  logic [N:0] ax, mx;
  assign ax = {a[N-1], a};
  assign mx = {m[N-1], m};
  always_comb
    s = !sg ? (q[0] ? {1'b0, a} + {1'b0, m} : {1'b0, a})
            : ({q[0], q_1} == 2'b10 ? ax - mx : {q[0], q_1} == 2'b01 ? ax + mx : ax);
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      q_1 <= 1'b0;
      sg <= 1'b0;
    end else if (go) begin
      q_1 <= 1'b0;
      sg <= signed_op;
    end else if (state == RUN) begin
      q_1 <= q[0];
    end
`else
  always_comb s = q[0] ? {1'b0, a} + {1'b0, m} : {1'b0, a};
`endif
  // Both modes share the same shift: the N+1-bit sum drops its LSB into Q.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      a <= '0;
      q <= '0;
      m <= '0;
      cnt <= '0;
      product <= '0;
    end else if (go) begin
      a <= '0;
      q <= multiplier;
      m <= multiplicand;
      cnt <= CW'(N);
      state <= RUN;
    end else if (state == RUN) begin
      a <= s[N:1];
      q <= {s[0], q[N-1:1]};
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        product <= {s[N:1], s[0], q[N-1:1]};
        state <= DONE;
      end
    end else if (state == DONE) begin
      state <= IDLE;
    end
endmodule
